// File: rtl/sparse_match_sequencer.sv
// Multi-cycle sparse mask matcher: walks W&A LSB-first and emits up to
// MAX_NUM_OUTPUT matches per beat with raw position and dense W/A indices.
module sparse_match_sequencer #(
   parameter int BITMASK_LENGTH = 16,
   parameter int INDEX_BITWIDTH = 5,
   parameter int MAX_NUM_OUTPUT = 2,
   parameter int COUNT_BITWIDTH = 2
) (
   input  logic                                     clock,
   input  logic                                     resetn,
   input  logic                                     ivalid,
   output logic                                     oready,
   input  logic [BITMASK_LENGTH-1:0]                bitmaskW,
   input  logic [BITMASK_LENGTH-1:0]                bitmaskA,
   output logic                                     ovalid,
   input  logic                                     iready,
   output logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] matchPos,
   output logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] matchIdxW,
   output logic [INDEX_BITWIDTH*MAX_NUM_OUTPUT-1:0] matchIdxA,
   output logic [COUNT_BITWIDTH-1:0]                numMatch,
   output logic                                     lastBeat
);
   localparam int BL  = BITMASK_LENGTH;
   localparam int IW  = INDEX_BITWIDTH;
   localparam int MNO = MAX_NUM_OUTPUT;
   localparam int CW  = COUNT_BITWIDTH;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state, state_next;

   logic [BL-1:0]     w_q, a_q, rem_q, rem_next;
   logic [MNO*IW-1:0] sel_pos, sel_idx_w, sel_idx_a;
   logic [CW-1:0]     sel_num;
   logic              load;

   // Each lane peels the lowest set bit off what earlier lanes left behind.
   always_comb begin : select
      logic [BL-1:0] cur;
      logic [IW-1:0] p, cw, ca;
      cur       = rem_q;
      sel_pos   = '0;
      sel_idx_w = '0;
      sel_idx_a = '0;
      sel_num   = '0;
      for (int k = 0; k < MNO; k++) begin
         p  = '0;
         cw = '0;
         ca = '0;
         if (|cur) begin
            for (int i = BL-1; i >= 0; i--)
               if (cur[i]) p = IW'(i);
            // Dense indices count the full latched masks, not the remainder.
            for (int i = 0; i < BL; i++)
               if (i < int'(p)) begin
                  cw = cw + IW'(w_q[i]);
                  ca = ca + IW'(a_q[i]);
               end
            sel_num = sel_num + CW'(1);
         end
         sel_pos[k*IW +: IW]   = p;
         sel_idx_w[k*IW +: IW] = cw;
         sel_idx_a[k*IW +: IW] = ca;
         cur = cur & (cur - BL'(1));
      end
      rem_next = cur;
   end

   always_comb begin
      state_next = state;
      oready     = 1'b0;
      load       = 1'b0;
      case (state)
         IDLE: begin
            oready = resetn;
            if (ivalid) state_next = RUN;
         end
         RUN: begin
            load = !ovalid || iready;
            if (load && rem_next == '0) state_next = DRAIN;
         end
         DRAIN: if (iready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         state     <= IDLE;
         w_q       <= '0;
         a_q       <= '0;
         rem_q     <= '0;
         ovalid    <= 1'b0;
         lastBeat  <= 1'b0;
         numMatch  <= '0;
         matchPos  <= '0;
         matchIdxW <= '0;
         matchIdxA <= '0;
      end else begin
         state <= state_next;
         if (state == IDLE && ivalid) begin
            w_q   <= bitmaskW;
            a_q   <= bitmaskA;
            rem_q <= bitmaskW & bitmaskA;
         end
         if (load) begin
            ovalid    <= 1'b1;
            lastBeat  <= (rem_next == '0);
            numMatch  <= sel_num;
            matchPos  <= sel_pos;
            matchIdxW <= sel_idx_w;
            matchIdxA <= sel_idx_a;
            rem_q     <= rem_next;
         end
         if (state == DRAIN && iready) begin
            ovalid    <= 1'b0;
            lastBeat  <= 1'b0;
            numMatch  <= '0;
            matchPos  <= '0;
            matchIdxW <= '0;
            matchIdxA <= '0;
         end
      end
   end
endmodule

// File: tb/tb_sparse_match_sequencer.sv
// Directed bench for sparse_match_sequencer: beat table plus stall and
// mid-transaction reset sequences.
module tb_sparse_match_sequencer;
   logic        clock = 1'b0;
   logic        resetn = 1'b0;
   logic        ivalid = 1'b0;
   logic        oready;
   logic [15:0] bitmaskW = '0;
   logic [15:0] bitmaskA = '0;
   logic        ovalid;
   logic        iready = 1'b1;
   logic [9:0]  matchPos, matchIdxW, matchIdxA;
   logic [1:0]  numMatch;
   logic        lastBeat;

   int total = 0;
   int bad = 0;

   sparse_match_sequencer dut (
      .clock(clock), .resetn(resetn), .ivalid(ivalid), .oready(oready),
      .bitmaskW(bitmaskW), .bitmaskA(bitmaskA), .ovalid(ovalid), .iready(iready),
      .matchPos(matchPos), .matchIdxW(matchIdxW), .matchIdxA(matchIdxA),
      .numMatch(numMatch), .lastBeat(lastBeat)
   );

   always #5 clock = ~clock;

   typedef struct {
      bit          start;
      logic [15:0] w, a;
      logic [9:0]  pos, iw, ia;
      logic [1:0]  num;
      logic        last;
   } vec_t;

   vec_t vecs[7];

   function automatic logic [63:0] beat_of(input vec_t v);
      return {30'd0, 1'b1, v.pos, v.iw, v.ia, v.num, v.last};
   endfunction

   function automatic logic [63:0] dut_beat();
      return {30'd0, ovalid, matchPos, matchIdxW, matchIdxA, numMatch, lastBeat};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, got, exp);
      end
   endtask

   task automatic send(input logic [15:0] w, input logic [15:0] a);
      int n;
      @(negedge clock);
      n = 0;
      while (!oready && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!oready) chk("send_timeout", 64'(oready), 64'd1);
      ivalid = 1'b1;
      bitmaskW = w;
      bitmaskA = a;
      @(posedge clock);
      #1 ivalid = 1'b0;
   endtask

   task automatic wait_beat(input string name);
      int n;
      @(negedge clock);
      n = 0;
      while (!ovalid && n < 20) begin
         @(negedge clock);
         n++;
      end
      if (!ovalid) chk({name, "_timeout"}, 64'(ovalid), 64'd1);
   endtask

   initial begin
      vecs[0] = '{1, 16'h00FF, 16'h0F0F, {5'd1, 5'd0}, {5'd1, 5'd0}, {5'd1, 5'd0}, 2'd2, 1'b0};
      vecs[1] = '{0, 16'h0,    16'h0,    {5'd3, 5'd2}, {5'd3, 5'd2}, {5'd3, 5'd2}, 2'd2, 1'b1};
      vecs[2] = '{1, 16'hF0F0, 16'hAA00, {5'd15, 5'd13}, {5'd7, 5'd5}, {5'd3, 5'd2}, 2'd2, 1'b1};
      vecs[3] = '{1, 16'hFFFF, 16'h0007, {5'd1, 5'd0}, {5'd1, 5'd0}, {5'd1, 5'd0}, 2'd2, 1'b0};
      vecs[4] = '{0, 16'h0,    16'h0,    {5'd0, 5'd2}, {5'd0, 5'd2}, {5'd0, 5'd2}, 2'd1, 1'b1};
      vecs[5] = '{1, 16'h1234, 16'h0000, 10'd0, 10'd0, 10'd0, 2'd0, 1'b1};
      vecs[6] = '{1, 16'h8000, 16'h8001, {5'd0, 5'd15}, {5'd0, 5'd0}, {5'd0, 5'd1}, 2'd1, 1'b1};

      #3;
      chk("reset_outputs", dut_beat(), 64'd0);
      chk("reset_oready", 64'(oready), 64'd0);
      @(negedge clock);
      resetn = 1'b1;
      @(negedge clock);
      chk("idle_oready", {62'd0, oready, ovalid}, 64'd2);

      for (int i = 0; i < 7; i++) begin
         if (vecs[i].start) send(vecs[i].w, vecs[i].a);
         wait_beat($sformatf("vec%0d", i));
         chk($sformatf("vec%0d_beat", i), dut_beat(), beat_of(vecs[i]));
         if (vecs[i].last) begin
            @(negedge clock);
            chk($sformatf("vec%0d_idle", i), {62'd0, oready, ovalid}, 64'd2);
         end
      end

      // Stall on beat1 with ignored ivalid pulses, then release.
      iready = 1'b0;
      send(16'h00FF, 16'h0F0F);
      wait_beat("stall");
      for (int c = 0; c < 3; c++) begin
         ivalid = 1'b1;
         bitmaskW = 16'hFFFF;
         bitmaskA = 16'hFFFF;
         chk($sformatf("stall_hold%0d", c), dut_beat(), beat_of(vecs[0]));
         chk($sformatf("stall_oready%0d", c), 64'(oready), 64'd0);
         @(negedge clock);
      end
      ivalid = 1'b0;
      iready = 1'b1;
      @(negedge clock);
      chk("stall_beat2", dut_beat(), beat_of(vecs[1]));
      @(negedge clock);
      chk("stall_idle", {62'd0, oready, ovalid}, 64'd2);

      // Reset while beat1 is stalled.
      iready = 1'b0;
      send(16'h00FF, 16'h0F0F);
      wait_beat("rst");
      chk("rst_pre", dut_beat(), beat_of(vecs[0]));
      #2 resetn = 1'b0;
      #1;
      chk("rst_async_clear", dut_beat(), 64'd0);
      chk("rst_oready", 64'(oready), 64'd0);
      @(negedge clock);
      resetn = 1'b1;
      iready = 1'b1;
      for (int c = 0; c < 4; c++) begin
         @(negedge clock);
         chk($sformatf("rst_quiet%0d", c), {61'd0, oready, ovalid, lastBeat}, 64'd4);
      end
      send(16'hF0F0, 16'hAA00);
      wait_beat("rst_after");
      chk("rst_after_beat", dut_beat(), beat_of(vecs[2]));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
